mod_mult_barrett_pipe: RTL
==========================

// Module: mod_mult_barrett_pipe
// PURPOSE
//  Pipelined Barrett modular multiplier: res = (a*b) mod q, for a run-time loadable odd modulus q.
//  Successor to the fixed-modulus 6145 multiplier used in the NTT butterfly datapath.
//  Adds: parametrised width, valid/ready flow control with back-pressure, a sideband tag,
//  and a safe modulus/mu reload.
//  Sits between the butterfly operand fetch and the add/sub stage; one result per cycle.
// PARAMETERS
//  W           13      modulus/operand width; q must satisfy 2^(W-1) < q < 2^W
//  TAG_W       4       sideband tag width, carried unchanged alongside each operand pair
//  MOD_RST     6145    modulus value after reset
//  MU_RST      10920   Barrett constant after reset; mu = floor(2^(2W)/q), W+1 bits
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        asynchronous, active-low reset
//  mod_load   in   1        request to replace q/mu (single-cycle pulse)
//  mod_q      in   W        new modulus, sampled when mod_load=1
//  mod_mu     in   W+1      new Barrett constant, sampled when mod_load=1
//  busy       out  1        1 while a modulus reload is pending
//  in_valid   in   1        operand pair valid
//  in_ready   out  1        block accepts the pair this cycle
//  in_a       in   W        operand a, must be < q
//  in_b       in   W        operand b, must be < q
//  in_tag     in   TAG_W    sideband tag
//  out_valid  out  1        result valid
//  out_ready  in   1        downstream accepts the result
//  out_res    out  W        (a*b) mod q, always in [0, q-1]
//  out_tag    out  TAG_W    tag of the same transaction
// BEHAVIOUR
//  - Reset: all stage valid bits, out_valid, busy, out_res and out_tag go to 0. q=MOD_RST, mu=MU_RST.
//  - 5 stages, each with a valid bit:
//      S1  p = a*b (2W bits)
//      S2  t = (p>>(W-1))*mu
//      S3  m = (t>>(W+1))*q
//      S4  r = p[W+1:0] - m[W+1:0], mod 2^(W+2); guaranteed r < 3q
//      S5  subtract 2q if r>=2q, else q if r>=q, else nothing; registered into out_res
//  - Latency: a pair accepted at edge N gives out_valid=1 after edge N+5, when there is no stall.
//  - Flow control: adv = !out_valid | out_ready. All stages shift together only when adv=1.
//    When adv=0, every stage register, including out_res/out_tag, holds.
//  - in_ready = adv & !busy. A transfer happens on in_valid & in_ready.
//    When no transfer happens and adv=1, a bubble (valid=0) enters S1.
//  - Output holds steady while out_valid & !out_ready (AXI-stream rules).
//  - Bubbles never produce out_valid. The throughput requirement is 1 result/cycle with out_ready held at 1.
//  - Modulus reload:
//      mod_load=1 captures mod_q/mod_mu into shadow registers and sets busy on the next edge.
//      in_ready drops from the cycle after mod_load.
//      Once all S1..S5 valid bits and out_valid are 0, active q/mu <= shadow and busy clears on the same edge.
//      Transactions already in flight complete with the old q/mu.
//  - Simultaneous mod_load and input transfer in one cycle: the pair is accepted and uses the OLD q.
//  - mod_load while busy=1: the shadow is overwritten and the last value wins; only one commit happens.
//  - Reset mid-operation: the pipeline is flushed, in-flight results are lost, and any pending reload is discarded.
//  - Operands >= q, or q/mu outside the stated range: out_res is unspecified, but the protocol stays correct.
// STRUCTURE
//  - Shared package holds MOD_RST/MU_RST constants for 6145 and 7681, plus a mu width function (W+1).
//  - One sub-module, mod_mult_barrett_corr: the combinational S5 conditional subtract of 2q/q, W+2 -> W bits.
//    It is reused by the planned mod_add/mod_sub blocks.
//  - Multiplies are plain '*'; the synthesis tool maps them to DSPs. No other hierarchy.
// TESTING
//  1. After reset with out_ready=1, drive (6144, 6144, tag 3) -> out_res=1, out_tag=3, exactly 5 cycles later.
//  2. Stream (0,5), (100,200), (6144,1), (1,1) back-to-back -> results 0, 1565, 6144, 1 in order, one per cycle.
//  3. Hold out_ready=0 for 4 cycles while streaming.
//       -> in_ready=0 during the stall, out_res/out_tag stable, no loss and no duplicates after release.
//  4. mod_load q=7681, mu=8736 with 3 pairs in flight.
//       -> the 3 pairs use q=6145, busy=1 until drain, then (7680,7680) gives 1.
//  5. Assert rst mid-stream and mid-reload.
//       -> out_valid=0 and busy=0 immediately; q=6145 afterwards, (6144,6144) gives 1.
//  6. 10k random a,b < q for both moduli, with random out_ready.
//       -> the scoreboard matches (a*b)%q and the tags in order.

Source files
------------

// File: rtl/mod_mult_barrett_pipe_pkg.sv
// Shared constants and helpers for the Barrett modular multiplier family.
package mod_mult_barrett_pipe_pkg;

   // Supported NTT moduli and their Barrett constants, mu = floor(2^26 / q).
   localparam int unsigned MOD_6145 = 6145;
   localparam int unsigned MU_6145  = 10920;
   localparam int unsigned MOD_7681 = 7681;
   localparam int unsigned MU_7681  = 8736;

   // Barrett constant is one bit wider than the modulus.
   function automatic int unsigned mu_width(input int unsigned w);
      return w + 1;
   endfunction

endpackage

// File: rtl/mod_mult_barrett_pipe_if.sv
// Operand, result and modulus-reload signals of the Barrett multiplier.
interface mod_mult_barrett_pipe_if
   import mod_mult_barrett_pipe_pkg::*;
#(
   parameter int unsigned W     = 13,
   parameter int unsigned TAG_W = 4
);

   localparam int unsigned MW = mu_width(W);

   logic             mod_load;
   logic [W-1:0]     mod_q;
   logic [MW-1:0]    mod_mu;
   logic             busy;
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_a;
   logic [W-1:0]     in_b;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     out_res;
   logic [TAG_W-1:0] out_tag;

   // Upstream producer / downstream consumer side.
   modport master (
      output mod_load, mod_q, mod_mu, in_valid, in_a, in_b, in_tag, out_ready,
      input  busy, in_ready, out_valid, out_res, out_tag
   );

   // The multiplier itself.
   modport slave (
      input  mod_load, mod_q, mod_mu, in_valid, in_a, in_b, in_tag, out_ready,
      output busy, in_ready, out_valid, out_res, out_tag
   );

endinterface

// File: rtl/mod_mult_barrett_corr.sv
// Final Barrett correction: maps r in [0, 3q) to r mod q by subtracting 0, q or 2q.
module mod_mult_barrett_corr #(
   parameter int unsigned W = 13
) (
   input  logic [W+1:0] r,
   input  logic [W-1:0] q,
   output logic [W-1:0] res
);

   logic [W+1:0] q1;
   logic [W+1:0] q2;

   // Pick the largest multiple of q not exceeding r.
   always_comb begin
      q1  = (W+2)'(q);
      q2  = {1'b0, q, 1'b0};
      res = W'(r);
      if (r >= q2) begin
         res = W'(r - q2);
      end else if (r >= q1) begin
         res = W'(r - q1);
      end
   end

endmodule

// File: rtl/mod_mult_barrett_pipe.sv
// Pipelined Barrett modular multiplier, res = (a*b) mod q, with loadable modulus.
// Operand register, then p / t / m / r stages, then the corrected result register.
module mod_mult_barrett_pipe
   import mod_mult_barrett_pipe_pkg::*;
#(
   parameter int unsigned W       = 13,
   parameter int unsigned TAG_W   = 4,
   parameter int unsigned MOD_RST = MOD_6145,
   parameter int unsigned MU_RST  = MU_6145
) (
   input logic                    clk,
   input logic                    rst,
   mod_mult_barrett_pipe_if.slave bus
);

   localparam int unsigned MW = mu_width(W);
   localparam int unsigned RW = W + 2;

   logic [W-1:0]     q_act, q_shd;
   logic [MW-1:0]    mu_act, mu_shd;
   logic             busy_q;

   logic             v_op, v_p, v_t, v_m, v_r, out_valid_q;
   logic [W-1:0]     a_op, b_op;
   logic [TAG_W-1:0] tag_op, tag_p, tag_t, tag_m, tag_r, tag_out;
   logic [2*W-1:0]   p_q;
   logic [W:0]       qh_q;
   logic [RW-1:0]    plo_t, plo_m, m_q, r_q;
   logic [W-1:0]     res_q;

   logic             adv, in_ready, accept, drained, commit;
   logic [2*W-1:0]   p_d;
   logic [W:0]       qh_d;
   logic [RW-1:0]    m_d, r_d;
   logic [W-1:0]     res_d;

   // Handshake, drain detection and per-stage arithmetic.
   always_comb begin
      adv      = !out_valid_q || bus.out_ready;
      in_ready = adv && !busy_q;
      accept   = bus.in_valid && in_ready;
      drained  = !(v_op || v_p || v_t || v_m || v_r || out_valid_q);
      commit   = busy_q && drained;
      p_d      = (2*W)'(a_op) * (2*W)'(b_op);
      qh_d     = (W+1)'(((2*W+2)'(p_q[2*W-1:W-1]) * (2*W+2)'(mu_act)) >> (W+1));
      // Only the low W+2 bits of m matter: r is known to fit there.
      m_d      = RW'(qh_q) * RW'(q_act);
      r_d      = plo_m - m_q;
   end

   mod_mult_barrett_corr #(
      .W (W)
   ) u_corr (
      .r   (r_q),
      .q   (q_act),
      .res (res_d)
   );

   // Modulus reload: shadow capture, busy flag, commit once the pipeline is empty.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_act  <= W'(MOD_RST);
         mu_act <= MW'(MU_RST);
         q_shd  <= W'(MOD_RST);
         mu_shd <= MW'(MU_RST);
         busy_q <= 1'b0;
      end else begin
         if (bus.mod_load) begin
            q_shd  <= bus.mod_q;
            mu_shd <= bus.mod_mu;
         end
         if (commit) begin
            // A load arriving on the commit edge is the newest value; take it directly.
            q_act  <= bus.mod_load ? bus.mod_q  : q_shd;
            mu_act <= bus.mod_load ? bus.mod_mu : mu_shd;
            busy_q <= 1'b0;
         end else if (bus.mod_load) begin
            busy_q <= 1'b1;
         end
      end
   end

   // Pipeline registers; everything shifts together on adv, otherwise holds.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v_op        <= 1'b0;
         v_p         <= 1'b0;
         v_t         <= 1'b0;
         v_m         <= 1'b0;
         v_r         <= 1'b0;
         out_valid_q <= 1'b0;
         a_op        <= '0;
         b_op        <= '0;
         p_q         <= '0;
         qh_q        <= '0;
         plo_t       <= '0;
         plo_m       <= '0;
         m_q         <= '0;
         r_q         <= '0;
         res_q       <= '0;
         tag_op      <= '0;
         tag_p       <= '0;
         tag_t       <= '0;
         tag_m       <= '0;
         tag_r       <= '0;
         tag_out     <= '0;
      end else if (adv) begin
         v_op        <= accept;
         v_p         <= v_op;
         v_t         <= v_p;
         v_m         <= v_t;
         v_r         <= v_m;
         out_valid_q <= v_r;
         a_op        <= bus.in_a;
         b_op        <= bus.in_b;
         p_q         <= p_d;
         qh_q        <= qh_d;
         plo_t       <= p_q[RW-1:0];
         plo_m       <= plo_t;
         m_q         <= m_d;
         r_q         <= r_d;
         res_q       <= res_d;
         tag_op      <= bus.in_tag;
         tag_p       <= tag_op;
         tag_t       <= tag_p;
         tag_m       <= tag_t;
         tag_r       <= tag_m;
         tag_out     <= tag_r;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_res   = res_q;
   assign bus.out_tag   = tag_out;

endmodule
